// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone round-robin arbiter.
//   arb_state_e    : arbiter FSM encoding (IDLE waits for requests, BUSY owns slave)
//   MAX_NM         : largest supported master count
//   onehot_to_idx  : converts a one-hot grant vector into a master index
// ----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int MAX_NM = 8;

    // Callers zero-extend their NM-bit grant to MAX_NM bits. The result is an
    // int so each caller can narrow it to its own index width with a cast.
    function automatic int onehot_to_idx(input logic [MAX_NM-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_NM; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_arbiter_if
// Bundle of every bus signal around the arbiter: NM packed master ports on
// one side and a single Wishbone classic slave port on the other.
// Signal names keep the arbiter's point of view (_i into it, _o out of it).
//   m_cyc_i/m_stb_i/m_we_i [NM]   per-master cycle, strobe, write enable
//   m_adr_i [NM*AW]               packed addresses, master k at [k*AW +: AW]
//   m_dat_i [NM*DW]               packed write data
//   m_sel_i [NM*DW/8]             packed byte selects
//   m_ack_o/m_err_o [NM]          ack / watchdog error to the granted master
//   m_dat_o [DW]                  slave read data broadcast to all masters
//   m_gnt_o [NM]                  one-hot grant, for visibility
//   s_cyc_o/s_stb_o/s_we_o        slave cycle, strobe, write enable
//   s_adr_o/s_dat_o/s_sel_o       slave address, write data, byte selects
//   s_ack_i/s_dat_i               slave ack and read data
// Modports:
//   master : the arbiter itself (it drives the slave bus)
//   slave  : the environment (the masters plus the slave device)
// ----------------------------------------------------------------------------
interface wb_arbiter_if #(
    parameter int NM = 2,
    parameter int AW = 10,
    parameter int DW = 32
);
    logic [NM-1:0]        m_cyc_i;
    logic [NM-1:0]        m_stb_i;
    logic [NM-1:0]        m_we_i;
    logic [NM*AW-1:0]     m_adr_i;
    logic [NM*DW-1:0]     m_dat_i;
    logic [NM*DW/8-1:0]   m_sel_i;
    logic [NM-1:0]        m_ack_o;
    logic [NM-1:0]        m_err_o;
    logic [DW-1:0]        m_dat_o;
    logic [NM-1:0]        m_gnt_o;
    logic                 s_cyc_o;
    logic                 s_stb_o;
    logic                 s_we_o;
    logic [AW-1:0]        s_adr_o;
    logic [DW-1:0]        s_dat_o;
    logic [DW/8-1:0]      s_sel_o;
    logic                 s_ack_i;
    logic [DW-1:0]        s_dat_i;

    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, m_gnt_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, m_gnt_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

endinterface

// File: rtl/wb_rr_pick.sv
// ----------------------------------------------------------------------------
// wb_rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// master (last+1) mod NM and returns the first requester as a one-hot vector.
//   req_i  [NM]  per-master requests
//   last_i [LW]  index of the previous owner
//   gnt_o  [NM]  one-hot next grant, zero when nobody requests
// ----------------------------------------------------------------------------
module wb_rr_pick #(
    parameter int NM = 2,
    parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [LW-1:0] last_i,
    output logic [NM-1:0] gnt_o
);

    logic [LW-1:0]   start;
    logic [2*NM-1:0] dbl;
    logic [NM-1:0]   rot;
    logic [NM-1:0]   pri;
    logic [2*NM-1:0] back;

    // Rotate so the search origin lands on bit 0, isolate the lowest set bit,
    // then rotate it back. Doubling the vector turns the rotates into shifts.
    always_comb begin
        start = (last_i == LW'(NM - 1)) ? '0 : last_i + LW'(1);
        dbl   = {req_i, req_i} >> start;
        rot   = dbl[NM-1:0];
        pri   = rot & (~rot + NM'(1));
        back  = {pri, pri} << start;
        gnt_o = back[2*NM-1:NM];
    end

endmodule

// File: rtl/wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
// Round-robin Wishbone classic arbiter sharing one slave among NM masters.
// A master keeps ownership for its whole cyc; a watchdog ends a slave access
// that goes TIMEOUT strobe cycles without ack by pulsing err to the owner.
// The data/ack path is purely combinational, so access latency is unchanged.
//   clk_i  : clock, all logic on the rising edge
//   rst_i  : synchronous reset, active high
//   bus    : wb_arbiter_if master modport (masters side + slave side);
//            its NM/AW/DW must match this module's parameters
// Parameters: NM (2..8), AW, DW, TIMEOUT (0 disables the watchdog)
// ----------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    wb_arbiter_if.master  bus
);

    localparam int LW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    arb_state_e       state_q;
    logic [NM-1:0]    gnt_q;
    logic [LW-1:0]    last_q;
    logic [CW-1:0]    wdog_q;
    logic [CW-1:0]    wdog_d;

    logic [NM-1:0]     pick;
    logic [MAX_NM-1:0] gnt_ext;
    logic [MAX_NM-1:0] pick_ext;
    logic [LW-1:0]     g_idx;
    logic [LW-1:0]     pick_idx;
    logic              busy;
    logic              own_cyc;
    logic              stb_raw;
    logic              wd_err;

    wb_rr_pick #(
        .NM (NM),
        .LW (LW)
    ) u_pick (
        .req_i  (bus.m_cyc_i),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    always_comb begin
        gnt_ext            = '0;
        gnt_ext[NM-1:0]    = gnt_q;
        pick_ext           = '0;
        pick_ext[NM-1:0]   = pick;
    end

    assign g_idx    = LW'(onehot_to_idx(gnt_ext));
    assign pick_idx = LW'(onehot_to_idx(pick_ext));

    // Owner view: cyc follows the granted master directly, so dropping cyc
    // releases the slave in the same cycle.
    assign busy    = (state_q == ARB_BUSY);
    assign own_cyc = busy & bus.m_cyc_i[g_idx];
    assign stb_raw = own_cyc & bus.m_stb_i[g_idx];

    // Error cycle: strobe is withheld and any late ack is ignored, so ack and
    // err can never reach the master together.
    assign wd_err  = (TIMEOUT != 0) && stb_raw && (wdog_q == TO_VAL);

    assign bus.s_cyc_o = own_cyc;
    assign bus.s_stb_o = stb_raw & ~wd_err;
    assign bus.s_we_o  = own_cyc & bus.m_we_i[g_idx];
    assign bus.s_adr_o = bus.m_adr_i[g_idx*AW +: AW];
    assign bus.s_dat_o = bus.m_dat_i[g_idx*DW +: DW];
    assign bus.s_sel_o = bus.m_sel_i[g_idx*SW +: SW];

    assign bus.m_ack_o = gnt_q & {NM{busy & bus.s_ack_i & ~wd_err}};
    assign bus.m_err_o = gnt_q & {NM{wd_err}};
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_gnt_o = gnt_q;

    // Counts strobe cycles still waiting for ack; any ack, idle strobe, error
    // cycle or release returns it to zero.
    always_comb begin
        wdog_d = '0;
        if ((TIMEOUT != 0) && bus.s_stb_o && !bus.s_ack_i) begin
            wdog_d = wdog_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            last_q  <= LW'(NM - 1);
            wdog_q  <= '0;
        end else begin
            wdog_q <= wdog_d;
            case (state_q)
                ARB_IDLE: begin
                    if (|bus.m_cyc_i) begin
                        gnt_q   <= pick;
                        last_q  <= pick_idx;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // Clearing the grant here leaves one dead cycle between owners.
                    if (!bus.m_cyc_i[g_idx]) begin
                        gnt_q   <= '0;
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter. dut_a: NM=2, TIMEOUT=8, backed by a small
// memory that acks one cycle after each strobe. dut_b: NM=3, default TIMEOUT,
// backed by an always-acking stub, used for the fairness sequence.
// ----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.NM(2), .AW(10), .DW(32)) bus_a ();
    wb_arbiter_if #(.NM(3), .AW(10), .DW(32)) bus_b ();

    wb_arbiter #(.NM(2), .AW(10), .DW(32), .TIMEOUT(8)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a.master)
    );

    wb_arbiter #(.NM(3), .AW(10), .DW(32), .TIMEOUT(255)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b.master)
    );

    // Slave memory behind dut_a
    logic [31:0] mem_a [0:1023];
    logic        ack_a = 1'b0;
    logic [31:0] rd_a  = 32'h0;
    logic        ack_en_a;
    int          wcnt_a = 0;

    assign bus_a.s_ack_i = ack_a;
    assign bus_a.s_dat_i = rd_a;

    always @(posedge clk) begin
        if (bus_a.s_stb_o && !ack_a && ack_en_a) begin
            ack_a <= 1'b1;
            rd_a  <= mem_a[bus_a.s_adr_o];
            if (bus_a.s_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus_a.s_sel_o[b]) begin
                        mem_a[bus_a.s_adr_o][b*8 +: 8] <= bus_a.s_dat_o[b*8 +: 8];
                    end
                end
                wcnt_a <= wcnt_a + 1;
            end
        end else begin
            ack_a <= 1'b0;
        end
    end

    // Always-acking stub behind dut_b
    logic ack_b = 1'b0;
    assign bus_b.s_ack_i = ack_b;
    assign bus_b.s_dat_i = 32'h0;
    always @(posedge clk) ack_b <= bus_b.s_stb_o && !ack_b;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m_a(input int k, input logic cyc, input logic stb, input logic we,
                           input logic [9:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus_a.m_cyc_i[k]          = cyc;
        bus_a.m_stb_i[k]          = stb;
        bus_a.m_we_i[k]           = we;
        bus_a.m_adr_i[k*10 +: 10] = adr;
        bus_a.m_dat_i[k*32 +: 32] = dat;
        bus_a.m_sel_i[k*4 +: 4]   = sel;
    endtask

    // Returns the number of negedges until master k sees ack, -1 on timeout.
    task automatic wait_ack_a(input int k, output int lat);
        lat = -1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (bus_a.m_ack_o[k]) begin
                lat = i;
                break;
            end
        end
    endtask

    function automatic int oh_idx(input logic [2:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    int          lat;
    int          w0;
    int          seq [6];
    int          ngr;
    logic [2:0]  g_b, a_b, prev_b, drop_b;

    initial begin
        rst        = 1'b1;
        ack_en_a   = 1'b1;
        bus_a.m_cyc_i = '0; bus_a.m_stb_i = '0; bus_a.m_we_i = '0;
        bus_a.m_adr_i = '0; bus_a.m_dat_i = '0; bus_a.m_sel_i = '0;
        bus_b.m_cyc_i = '0; bus_b.m_stb_i = '0; bus_b.m_we_i = '0;
        bus_b.m_adr_i = '0; bus_b.m_dat_i = '0; bus_b.m_sel_i = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_s_cyc", bus_a.s_cyc_o, 0);
        chk("rst_s_stb", bus_a.s_stb_o, 0);
        chk("rst_gnt",   bus_a.m_gnt_o, 0);
        chk("rst_ack",   bus_a.m_ack_o, 0);
        chk("rst_err",   bus_a.m_err_o, 0);
        chk("rst_gnt_b", bus_b.m_gnt_o, 0);
        rst = 1'b0;

        // 1: single master write then read
        set_m_a(0, 1, 1, 1, 10'h010, 32'hDEADBEEF, 4'hF);
        #1;
        chk("t1_cyc_same_cycle", bus_a.s_cyc_o, 0);
        @(negedge clk);
        chk("t1_cyc_next_cycle", bus_a.s_cyc_o, 1);
        chk("t1_gnt",  bus_a.m_gnt_o, 2'b01);
        chk("t1_adr",  bus_a.s_adr_o, 10'h010);
        chk("t1_we",   bus_a.s_we_o, 1);
        chk("t1_sdat", bus_a.s_dat_o, 32'hDEADBEEF);
        wait_ack_a(0, lat);
        chk("t1_wr_lat", lat, 1);
        chk("t1_wr_ack", bus_a.m_ack_o, 2'b01);
        set_m_a(0, 0, 0, 0, 10'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_dead_gnt", bus_a.m_gnt_o, 0);
        set_m_a(0, 1, 1, 0, 10'h010, 32'h0, 4'hF);
        wait_ack_a(0, lat);
        chk("t1_rd_lat",  lat, 2);
        chk("t1_rd_data", bus_a.m_dat_o, 32'hDEADBEEF);
        chk("t1_rd_ack",  bus_a.m_ack_o, 2'b01);
        set_m_a(0, 0, 0, 0, 10'h0, 32'h0, 4'h0);
        @(negedge clk);

        // 3: NM=3 fairness, all masters requesting continuously
        for (int j = 0; j < 6; j++) seq[j] = -1;
        ngr = 0; prev_b = '0; drop_b = '0;
        bus_b.m_cyc_i = 3'b111;
        bus_b.m_stb_i = 3'b111;
        for (int i = 0; i < 80 && ngr < 6; i++) begin
            @(negedge clk);
            g_b = bus_b.m_gnt_o;
            a_b = bus_b.m_ack_o;
            chk("t3_onehot", ((g_b & (g_b - 3'd1)) == 3'd0), 1);
            if (g_b != 3'd0 && prev_b == 3'd0) begin
                seq[ngr] = oh_idx(g_b);
                ngr++;
            end
            prev_b = g_b;
            for (int k = 0; k < 3; k++) begin
                if (drop_b[k]) begin
                    bus_b.m_cyc_i[k] = 1'b1;
                    bus_b.m_stb_i[k] = 1'b1;
                    drop_b[k] = 1'b0;
                end else if (a_b[k]) begin
                    bus_b.m_cyc_i[k] = 1'b0;
                    bus_b.m_stb_i[k] = 1'b0;
                    drop_b[k] = 1'b1;
                end
            end
        end
        chk("t3_grants", ngr, 6);
        for (int j = 0; j < 6; j++) chk($sformatf("t3_seq%0d", j), seq[j], j % 3);
        bus_b.m_cyc_i = '0;
        bus_b.m_stb_i = '0;

        // 2: both masters request together after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_m_a(0, 1, 1, 0, 10'h010, 32'h0, 4'hF);
        set_m_a(1, 1, 1, 0, 10'h010, 32'h0, 4'hF);
        @(negedge clk);
        chk("t2_gnt_first", bus_a.m_gnt_o, 2'b01);
        wait_ack_a(0, lat);
        chk("t2_m0_lat", lat, 1);
        chk("t2_m0_ack", bus_a.m_ack_o, 2'b01);
        set_m_a(0, 0, 0, 0, 10'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t2_idle_gnt", bus_a.m_gnt_o, 0);
        chk("t2_idle_cyc", bus_a.s_cyc_o, 0);
        @(negedge clk);
        chk("t2_gnt_second", bus_a.m_gnt_o, 2'b10);
        chk("t2_cyc_second", bus_a.s_cyc_o, 1);
        wait_ack_a(1, lat);
        chk("t2_m1_lat",  lat, 1);
        chk("t2_m1_data", bus_a.m_dat_o, 32'hDEADBEEF);
        chk("t2_m1_ack",  bus_a.m_ack_o, 2'b10);
        set_m_a(1, 0, 0, 0, 10'h0, 32'h0, 4'h0);
        @(negedge clk);

        // 4: slave never acks, watchdog fires on the 9th strobe cycle
        ack_en_a = 1'b0;
        set_m_a(0, 1, 1, 0, 10'h030, 32'h0, 4'hF);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("t4_err_c%0d", i), bus_a.m_err_o, (i == 9) ? 2'b01 : 2'b00);
            chk($sformatf("t4_stb_c%0d", i), bus_a.s_stb_o, (i == 9) ? 1'b0 : 1'b1);
            chk($sformatf("t4_ack_c%0d", i), bus_a.m_ack_o, 2'b00);
        end
        chk("t4_keeps_gnt", bus_a.m_gnt_o, 2'b01);
        set_m_a(0, 0, 0, 0, 10'h0, 32'h0, 4'h0);
        @(negedge clk);

        // 5: reset while master 1 owns the slave
        set_m_a(1, 1, 1, 0, 10'h030, 32'h0, 4'hF);
        @(negedge clk);
        chk("t5_gnt_m1", bus_a.m_gnt_o, 2'b10);
        chk("t5_cyc_m1", bus_a.s_cyc_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_cyc", bus_a.s_cyc_o, 0);
        chk("t5_rst_stb", bus_a.s_stb_o, 0);
        chk("t5_rst_gnt", bus_a.m_gnt_o, 0);
        rst = 1'b0;
        set_m_a(0, 1, 1, 0, 10'h030, 32'h0, 4'hF);
        @(negedge clk);
        chk("t5_first_after_rst", bus_a.m_gnt_o, 2'b01);
        set_m_a(0, 0, 0, 0, 10'h0, 32'h0, 4'h0);
        set_m_a(1, 0, 0, 0, 10'h0, 32'h0, 4'h0);
        ack_en_a = 1'b1;
        @(negedge clk);

        // 6: non-owner toggles a write strobe while master 0 owns the bus
        set_m_a(0, 1, 0, 0, 10'h010, 32'h0, 4'hF);
        @(negedge clk);
        chk("t6_gnt_m0", bus_a.m_gnt_o, 2'b01);
        w0 = wcnt_a;
        for (int i = 0; i < 6; i++) begin
            set_m_a(1, 1, (i % 2) == 1, 1, 10'h020, 32'h12345678, 4'hF);
            @(negedge clk);
            chk($sformatf("t6_stb_%0d", i), bus_a.s_stb_o, 0);
            chk($sformatf("t6_we_%0d", i),  bus_a.s_we_o, 0);
            chk($sformatf("t6_ack_%0d", i), bus_a.m_ack_o, 2'b00);
        end
        chk("t6_no_write", wcnt_a, w0);
        set_m_a(0, 1, 1, 0, 10'h010, 32'h0, 4'hF);
        wait_ack_a(0, lat);
        chk("t6_owner_lat",  lat, 1);
        chk("t6_owner_data", bus_a.m_dat_o, 32'hDEADBEEF);
        chk("t6_owner_ack",  bus_a.m_ack_o, 2'b01);
        set_m_a(0, 0, 0, 0, 10'h0, 32'h0, 4'h0);
        set_m_a(1, 0, 0, 0, 10'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
